sam3_seq_ctrl: RTL and testbench
================================

SAM3_SEQ_CTRL -- requirements
Module: sam3_seq_ctrl

Interface
REQ-001 Parameter: CAP_DELAY, default 1, cycles between first arr_mult_over high and capture of column 0.
REQ-002 Parameter: TMO_CYC, default 32, watchdog limit in WAIT state (used only with the watchdog macro).
REQ-003 clock  in  1  single clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request to multiply a_in by b_in; accepted when start and start_ready are both high.
REQ-006 start_ready  out  1  high only in IDLE.
REQ-007 a_in  in  36  matrix A, 4-bit unsigned, A[i][j] = a_in[4*(3i+j)+:4].
REQ-008 b_in  in  36  matrix B, same packing as a_in.
REQ-009 c_out  out  90  result C, 10-bit unsigned, C[i][j] = c_out[10*(3i+j)+:10].
REQ-010 res_valid  out  1  c_out valid; held until res_ready.
REQ-011 res_ready  in  1  consumer accepts result.
REQ-012 err  out  1  one-cycle watchdog timeout pulse.
REQ-013 arr_en, arr_reset  out  1 each  enable and clear to the 3x3 systolic array.
REQ-014 arr_a_row0..2, arr_b_col0..2  out  4 each  skewed operand streams to the array.
REQ-015 arr_c_row0..2  in  10 each  serialized result rows from the array.
REQ-016 arr_mult_over  in  1  array accumulation-complete flag.

Function
REQ-017 States: IDLE, CLR, FEED, WAIT, DRAIN, DONE; one-hot or binary is an implementation choice.
REQ-018 On handshake in IDLE: a_in and b_in are registered locally, next state CLR; start outside IDLE is ignored and does not change the captured operands.
REQ-019 IDLE and CLR: arr_en=0, arr_reset=1; all other states: arr_en=1, arr_reset=0.
REQ-020 CLR lasts exactly 1 cycle, then FEED.
REQ-021 FEED lasts exactly 5 cycles, counter t=0..4.
REQ-022 In FEED: arr_a_row_i = A[i][t-i] and arr_b_col_j = B[t-j][j] when the index is in 0..2, else 0.
REQ-023 Outside FEED all arr_a_row/arr_b_col outputs are 0.
REQ-024 After t=4, go to WAIT; WAIT exits to DRAIN on the first cycle arr_mult_over=1.
REQ-025 In DRAIN, counter d starts at 0 in the cycle after the WAIT exit.
REQ-026 In DRAIN, for d = CAP_DELAY+k (k=0..2): C[i][k] <= arr_c_row_i for i=0..2.
REQ-027 DRAIN lasts CAP_DELAY+3 cycles, then DONE.
REQ-028 DONE: res_valid=1 and c_out stable; on res_ready=1, res_valid drops next cycle and the state returns to IDLE.
REQ-029 c_out holds its last value in all states except DRAIN capture cycles.
REQ-030 No arithmetic on data paths; bit widths pass through unchanged, and the maximum element 675 fits in 10 bits.
REQ-031 Start-to-res_valid latency = 1 (accept) + 1 (CLR) + 5 (FEED) + WAIT cycles + CAP_DELAY + 3.

Reset
REQ-032 While reset=1 at a clock edge, the following values are forced next cycle: state=IDLE, all counters 0, c_out=0, res_valid=0, err=0, start_ready=1, arr_en=0, arr_reset=1, operand outputs 0.
REQ-033 Reset in any state, including mid-FEED or DONE with res_valid high, aborts the operation with no result produced.

Configuration
REQ-034 Macro SAM3_CTRL_WATCHDOG_EN defined: a WAIT cycle counter runs; if it reaches TMO_CYC without arr_mult_over, err pulses for 1 cycle and the state goes to IDLE with c_out unchanged and no res_valid.
REQ-035 Macro SAM3_CTRL_WATCHDOG_EN undefined: no counter is built, err is tied to 0, and WAIT waits indefinitely.

Verification
REQ-036 A=identity, B={1..9} row-major, start pulse -> res_valid after latency REQ-031, c_out elements = 1..9.
REQ-037 A=B=all 15 -> every C[i][j]=675; arr_a_row0 sequence across FEED = 15,15,15,0,0; arr_a_row2 = 0,0,15,15,15.
REQ-038 res_ready held low 20 cycles in DONE -> res_valid and c_out stable; start pulses during this time are ignored and start_ready=0.
REQ-039 reset asserted at FEED t=2 -> next cycle state IDLE, arr_reset=1, res_valid never asserts; a new start then yields a correct result.
REQ-040 With the macro defined, arr_mult_over tied 0 and TMO_CYC=32 -> err pulses once after 32 WAIT cycles and start_ready returns to 1; with the macro undefined, err stays 0.

Source files
------------

// File: rtl/sam3_seq_ctrl_if.sv
// Host-side handshake bundle for sam3_seq_ctrl: operand request, result return, error pulse.
interface sam3_seq_ctrl_if;
  logic        start;
  logic        start_ready;
  logic [35:0] a_in;
  logic [35:0] b_in;
  logic [89:0] c_out;
  logic        res_valid;
  logic        res_ready;
  logic        err;

  modport master (
    output start, a_in, b_in, res_ready,
    input  start_ready, c_out, res_valid, err
  );

  modport slave (
    input  start, a_in, b_in, res_ready,
    output start_ready, c_out, res_valid, err
  );
endinterface

// File: rtl/sam3_seq_ctrl.sv
// Sequencer for a 3x3 systolic matrix multiplier: skews operands in, captures result columns out.
// Optional WAIT-state watchdog enabled by defining SAM3_CTRL_WATCHDOG_EN.
module sam3_seq_ctrl #(
  parameter int unsigned CAP_DELAY = 1,
  parameter int unsigned TMO_CYC   = 32
) (
  input  logic              clock,
  input  logic              reset,
  sam3_seq_ctrl_if.slave    host,
  output logic              arr_en,
  output logic              arr_reset,
  output logic [3:0]        arr_a_row0,
  output logic [3:0]        arr_a_row1,
  output logic [3:0]        arr_a_row2,
  output logic [3:0]        arr_b_col0,
  output logic [3:0]        arr_b_col1,
  output logic [3:0]        arr_b_col2,
  input  logic [9:0]        arr_c_row0,
  input  logic [9:0]        arr_c_row1,
  input  logic [9:0]        arr_c_row2,
  input  logic              arr_mult_over
);

  typedef enum logic [2:0] {StIdle, StClr, StFeed, StWait, StDrain, StDone} state_e;

  localparam logic [7:0] CapFirst = 8'(CAP_DELAY);
  localparam logic [7:0] CapLast  = 8'(CAP_DELAY + 2);

  state_e      state_q;
  logic [2:0]  t_q;
  logic [7:0]  d_q;
  logic [35:0] a_q, b_q;
  logic [89:0] c_q;
  logic        valid_q, ready_q, en_q, arst_q;
  logic [11:0] a_ops_q, b_ops_q;

  // Row i of A enters at t = i + j, column j of B at t = row + j.
  function automatic logic [11:0] skew_a(input logic [35:0] m, input logic [2:0] t);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (int'(t) == i + j) r[4*i +: 4] = m[4*(3*i+j) +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] skew_b(input logic [35:0] m, input logic [2:0] t);
    logic [11:0] r;
    r = '0;
    for (int j = 0; j < 3; j++) begin
      for (int rr = 0; rr < 3; rr++) begin
        if (int'(t) == rr + j) r[4*j +: 4] = m[4*(3*rr+j) +: 4];
      end
    end
    return r;
  endfunction

`ifdef SAM3_CTRL_WATCHDOG_EN
  localparam logic [15:0] TmoLast = 16'(TMO_CYC - 1);
  logic [15:0] wdt_q;
  logic        err_q;
  assign host.err = err_q;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TMO_CYC;
  assign host.err   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      t_q     <= '0;
      d_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      en_q    <= 1'b0;
      arst_q  <= 1'b1;
      a_ops_q <= '0;
      b_ops_q <= '0;
`ifdef SAM3_CTRL_WATCHDOG_EN
      wdt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
`ifdef SAM3_CTRL_WATCHDOG_EN
      err_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (host.start) begin
            a_q     <= host.a_in;
            b_q     <= host.b_in;
            ready_q <= 1'b0;
            state_q <= StClr;
          end
        end
        StClr: begin
          state_q <= StFeed;
          t_q     <= '0;
          en_q    <= 1'b1;
          arst_q  <= 1'b0;
          a_ops_q <= skew_a(a_q, 3'd0);
          b_ops_q <= skew_b(b_q, 3'd0);
        end
        StFeed: begin
          if (t_q == 3'd4) begin
            state_q <= StWait;
            t_q     <= '0;
            a_ops_q <= '0;
            b_ops_q <= '0;
`ifdef SAM3_CTRL_WATCHDOG_EN
            wdt_q   <= '0;
`endif
          end else begin
            t_q     <= t_q + 3'd1;
            a_ops_q <= skew_a(a_q, t_q + 3'd1);
            b_ops_q <= skew_b(b_q, t_q + 3'd1);
          end
        end
        StWait: begin
          if (arr_mult_over) begin
            state_q <= StDrain;
            d_q     <= '0;
          end
`ifdef SAM3_CTRL_WATCHDOG_EN
          else if (wdt_q == TmoLast) begin
            state_q <= StIdle;
            err_q   <= 1'b1;
            ready_q <= 1'b1;
            en_q    <= 1'b0;
            arst_q  <= 1'b1;
            wdt_q   <= '0;
          end else begin
            wdt_q <= wdt_q + 16'd1;
          end
`endif
        end
        StDrain: begin
          // Array emits one result column per cycle once its pipeline latency has passed.
          for (int k = 0; k < 3; k++) begin
            if (d_q == CapFirst + 8'(k)) begin
              c_q[10*k     +: 10] <= arr_c_row0;
              c_q[10*(3+k) +: 10] <= arr_c_row1;
              c_q[10*(6+k) +: 10] <= arr_c_row2;
            end
          end
          if (d_q == CapLast) begin
            state_q <= StDone;
            d_q     <= '0;
            valid_q <= 1'b1;
          end else begin
            d_q <= d_q + 8'd1;
          end
        end
        StDone: begin
          if (host.res_ready) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            en_q    <= 1'b0;
            arst_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign host.start_ready = ready_q;
  assign host.res_valid   = valid_q;
  assign host.c_out       = c_q;
  assign arr_en           = en_q;
  assign arr_reset        = arst_q;
  assign arr_a_row0       = a_ops_q[3:0];
  assign arr_a_row1       = a_ops_q[7:4];
  assign arr_a_row2       = a_ops_q[11:8];
  assign arr_b_col0       = b_ops_q[3:0];
  assign arr_b_col1       = b_ops_q[7:4];
  assign arr_b_col2       = b_ops_q[11:8];

endmodule

// File: tb/tb_sam3_seq_ctrl.sv
// Self-checking bench for sam3_seq_ctrl: reference matrix product and cycle-indexed expectations.
module tb_sam3_seq_ctrl;
  localparam int unsigned CAP = 1;
  localparam int unsigned TMO = 32;

  logic       clock = 1'b0;
  logic       reset;
  logic       arr_en, arr_reset, arr_mult_over;
  logic [3:0] arr_a_row0, arr_a_row1, arr_a_row2;
  logic [3:0] arr_b_col0, arr_b_col1, arr_b_col2;
  logic [9:0] arr_c_row0, arr_c_row1, arr_c_row2;

  sam3_seq_ctrl_if host ();

  sam3_seq_ctrl #(.CAP_DELAY(CAP), .TMO_CYC(TMO)) dut (
    .clock         (clock),
    .reset         (reset),
    .host          (host),
    .arr_en        (arr_en),
    .arr_reset     (arr_reset),
    .arr_a_row0    (arr_a_row0),
    .arr_a_row1    (arr_a_row1),
    .arr_a_row2    (arr_a_row2),
    .arr_b_col0    (arr_b_col0),
    .arr_b_col1    (arr_b_col1),
    .arr_b_col2    (arr_b_col2),
    .arr_c_row0    (arr_c_row0),
    .arr_c_row1    (arr_c_row1),
    .arr_c_row2    (arr_c_row2),
    .arr_mult_over (arr_mult_over)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  logic [89:0] prev_c;

  task automatic chk(input string tag, input logic [89:0] obs, input logic [89:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [35:0] rnd36();
    return 36'({$urandom(), $urandom()});
  endfunction

  function automatic int el(input logic [35:0] m, input int r, input int c);
    return int'(m[4*(3*r+c) +: 4]);
  endfunction

  function automatic logic [89:0] matmul(input logic [35:0] a, input logic [35:0] b);
    logic [89:0] res;
    int s;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += el(a, i, k) * el(b, k, j);
        res[10*(3*i+j) +: 10] = 10'(s);
      end
    end
    return res;
  endfunction

  // Expected operand streams at feed step t (t outside 0..4 means not feeding).
  function automatic logic [11:0] exp_a(input logic [35:0] m, input int t);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 3; i++)
      if (t >= 0 && t <= 4 && t - i >= 0 && t - i <= 2) r[4*i +: 4] = 4'(el(m, i, t - i));
    return r;
  endfunction

  function automatic logic [11:0] exp_b(input logic [35:0] m, input int t);
    logic [11:0] r;
    r = '0;
    for (int j = 0; j < 3; j++)
      if (t >= 0 && t <= 4 && t - j >= 0 && t - j <= 2) r[4*j +: 4] = 4'(el(m, t - j, j));
    return r;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 90'(host.start_ready), 90'(1));
    chk({tag, "_arst"}, 90'(arr_reset), 90'(1));
    chk({tag, "_en"}, 90'(arr_en), 90'(0));
    chk({tag, "_valid"}, 90'(host.res_valid), 90'(0));
    chk({tag, "_aops"}, 90'({arr_a_row2, arr_a_row1, arr_a_row0}), 90'(0));
    chk({tag, "_bops"}, 90'({arr_b_col2, arr_b_col1, arr_b_col0}), 90'(0));
  endtask

  // One full transaction from an IDLE cycle. WAIT lasts w0+1 cycles, DONE is held hold+1 cycles.
  task automatic run_op(input string tag, input logic [35:0] a, input logic [35:0] b,
                        input int w0, input int hold);
    logic [89:0] cm;
    int w, dc, cap0, last;
    bit ev_ready, ev_arst, ev_valid;
    cm   = matmul(a, b);
    w    = w0 + 1;
    dc   = 10 + w + int'(CAP);
    cap0 = 7 + w + int'(CAP);
    last = dc + hold + 1;
    for (int c = 0; c <= last; c++) begin
      ev_ready = (c == 0 || c == last);
      ev_arst  = (c <= 1 || c == last);
      ev_valid = (c >= dc && c <= dc + hold);
      chk({tag, "_ready"}, 90'(host.start_ready), 90'(ev_ready));
      chk({tag, "_arst"}, 90'(arr_reset), 90'(ev_arst));
      chk({tag, "_en"}, 90'(arr_en), 90'(!ev_arst));
      chk({tag, "_valid"}, 90'(host.res_valid), 90'(ev_valid));
      chk({tag, "_aops"}, 90'({arr_a_row2, arr_a_row1, arr_a_row0}), 90'(exp_a(a, c - 2)));
      chk({tag, "_bops"}, 90'({arr_b_col2, arr_b_col1, arr_b_col0}), 90'(exp_b(b, c - 2)));
      chk({tag, "_err"}, 90'(host.err), 90'(0));
      if (c == 1) chk({tag, "_c_hold"}, host.c_out, prev_c);
      if (c >= dc) chk({tag, "_c_out"}, host.c_out, cm);

      if (c == 0) begin
        host.start = 1'b1;
        host.a_in  = a;
        host.b_in  = b;
      end else begin
        host.start = (c < last) && ($urandom_range(0, 2) == 0);
        host.a_in  = rnd36();
        host.b_in  = rnd36();
      end
      host.res_ready = (c == dc + hold) || (c < dc && $urandom_range(0, 1) == 1);
      arr_mult_over  = (c >= 7 + w0 && c < dc);
      if (c >= cap0 && c <= cap0 + 2) begin
        arr_c_row0 = cm[10*(c-cap0)     +: 10];
        arr_c_row1 = cm[10*(3+c-cap0)   +: 10];
        arr_c_row2 = cm[10*(6+c-cap0)   +: 10];
      end else begin
        arr_c_row0 = 10'($urandom);
        arr_c_row1 = 10'($urandom);
        arr_c_row2 = 10'($urandom);
      end
      tick();
    end
    host.start     = 1'b0;
    host.res_ready = 1'b0;
    arr_mult_over  = 1'b0;
    prev_c = cm;
  endtask

  initial begin
    logic [89:0] exp_c;
    logic [35:0] ra, rb;
    reset          = 1'b1;
    host.start     = 1'b0;
    host.a_in      = '0;
    host.b_in      = '0;
    host.res_ready = 1'b0;
    arr_mult_over  = 1'b0;
    arr_c_row0     = '0;
    arr_c_row1     = '0;
    arr_c_row2     = '0;
    tick();
    tick();
    reset = 1'b0;
    chk_idle_outputs("reset");
    chk("reset_c", host.c_out, 90'(0));
    chk("reset_err", 90'(host.err), 90'(0));
    prev_c = '0;

    // Identity times 1..9 gives 1..9 back.
    run_op("ident", 36'h1_0001_0001, 36'h9_8765_4321, 0, 0);
    for (int k = 0; k < 9; k++) exp_c[10*k +: 10] = 10'(k + 1);
    chk("ident_elems", host.c_out, exp_c);

    // Largest operands: every element 675.
    run_op("max", 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 2, 0);
    for (int k = 0; k < 9; k++) exp_c[10*k +: 10] = 10'd675;
    chk("max_elems", host.c_out, exp_c);

    // Long DONE hold with stray start pulses.
    run_op("hold", rnd36(), rnd36(), 3, 20);

    for (int n = 0; n < 5; n++)
      run_op("rand", rnd36(), rnd36(), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));

    // Abort in FEED at t=2.
    ra = rnd36();
    rb = rnd36();
    host.start = 1'b1;
    host.a_in  = ra;
    host.b_in  = rb;
    tick();
    host.start = 1'b0;
    for (int c = 1; c < 4; c++) tick();
    chk("abort_aops_t2", 90'({arr_a_row2, arr_a_row1, arr_a_row0}), 90'(exp_a(ra, 2)));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle_outputs("abort");
    chk("abort_c", host.c_out, 90'(0));
    prev_c = '0;
    arr_mult_over = 1'b1;
    for (int c = 0; c < 30; c++) begin
      chk("abort_novalid", 90'(host.res_valid), 90'(0));
      tick();
    end
    arr_mult_over = 1'b0;
    run_op("after_abort", rnd36(), rnd36(), 1, 1);

    // Array never signals completion.
    host.start = 1'b1;
    host.a_in  = rnd36();
    host.b_in  = rnd36();
    tick();
    host.start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
`ifdef SAM3_CTRL_WATCHDOG_EN
      chk("wdt_err", 90'(host.err), 90'(c == 7 + int'(TMO)));
      if (c >= 7 + int'(TMO)) chk("wdt_ready", 90'(host.start_ready), 90'(1));
`else
      chk("wdt_err_off", 90'(host.err), 90'(0));
      chk("wdt_wait_ready", 90'(host.start_ready), 90'(0));
`endif
      chk("wdt_valid", 90'(host.res_valid), 90'(0));
      chk("wdt_c", host.c_out, prev_c);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle_outputs("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
